// File: rtl/rv_wb_arbiter_pkg.sv
// Shared types and helpers for the write-back arbiter and its load queue.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef WB_DEPTH
`define WB_DEPTH 4
`endif

package rv_wb_arbiter_pkg;

    localparam int REG_AW = 5;
    localparam int NREGS  = 32;

    // Which producer owns the register file write slot this cycle.
    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_EX   = 2'd1,
        SRC_LD   = 2'd2
    } wb_src_e;

    // One-hot decode of a register index into a 32-bit mask.
    function automatic logic [NREGS-1:0] onehot_rd(input logic [REG_AW-1:0] rd);
        logic [NREGS-1:0] m;
        m = {NREGS{1'b0}};
        m[rd] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/rv_configs.sv
// Global configuration defaults shared by the write-back block.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef WB_DEPTH
`define WB_DEPTH 4
`endif

// File: rtl/rv_wb_queue.sv
// Circular buffer of pending load write-backs. Each entry carries a live bit
// that a younger pipeline write to the same register can clear; killed
// entries still occupy a slot until they reach the head and are popped.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef WB_DEPTH
`define WB_DEPTH 4
`endif

module rv_wb_queue
    import rv_wb_arbiter_pkg::*;
#(
    parameter int XLEN  = `XLEN,
    parameter int DEPTH = `WB_DEPTH
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   enq_i,
    input  logic [REG_AW-1:0]      enq_rd_i,
    input  logic [XLEN-1:0]        enq_data_i,
    input  logic                   deq_i,
    input  logic                   kill_i,
    input  logic [REG_AW-1:0]      kill_rd_i,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   head_live_o,
    output logic [REG_AW-1:0]      head_rd_o,
    output logic [XLEN-1:0]        head_data_o,
    output logic [NREGS-1:0]       busy_mask_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [REG_AW-1:0] rd_q   [DEPTH];
    logic [XLEN-1:0]   data_q [DEPTH];
    logic [DEPTH-1:0]  live_q, live_d;
    logic [PW-1:0]     head_q, head_d;
    logic [PW-1:0]     tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;

    // Live-bit update: kill older matches, retire the head, arm the new tail.
    always_comb begin
        live_d = live_q;
        if (kill_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (rd_q[i] == kill_rd_i) begin
                    live_d[i] = 1'b0;
                end else begin
                    live_d[i] = live_d[i];
                end
            end
        end else begin
            live_d = live_q;
        end
        if (deq_i) begin
            live_d[head_q] = 1'b0;
        end else begin
            live_d = live_d;
        end
        if (enq_i) begin
            live_d[tail_q] = 1'b1;
        end else begin
            live_d = live_d;
        end
    end

    // Pointer and occupancy next-state; pointers wrap naturally at DEPTH.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (deq_i) begin
            head_d = head_q + PW'(1);
        end else begin
            head_d = head_q;
        end
        if (enq_i) begin
            tail_d = tail_q + PW'(1);
        end else begin
            tail_d = tail_q;
        end
        case ({enq_i, deq_i})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Queue state registers; reset drops every pending load.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head_q  <= {PW{1'b0}};
            tail_q  <= {PW{1'b0}};
            count_q <= {CW{1'b0}};
            live_q  <= {DEPTH{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                rd_q[i]   <= {REG_AW{1'b0}};
                data_q[i] <= {XLEN{1'b0}};
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            live_q  <= live_d;
            if (enq_i) begin
                rd_q[tail_q]   <= enq_rd_i;
                data_q[tail_q] <= enq_data_i;
            end
        end
    end

    // Busy mask reflects only registered live entries, never this cycle's input.
    always_comb begin
        busy_mask_o = {NREGS{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            if (live_q[i]) begin
                busy_mask_o = busy_mask_o | onehot_rd(rd_q[i]);
            end else begin
                busy_mask_o = busy_mask_o;
            end
        end
    end

    assign count_o     = count_q;
    assign head_live_o = live_q[head_q];
    assign head_rd_o   = rd_q[head_q];
    assign head_data_o = data_q[head_q];

endmodule

// File: rtl/rv_wb_arbiter.sv
// Sole driver of the register file write port. Pipeline results always win
// the slot; queued load responses drain into idle cycles, and a pipeline
// write kills any older queued load to the same register.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef WB_DEPTH
`define WB_DEPTH 4
`endif

module rv_wb_arbiter
    import rv_wb_arbiter_pkg::*;
#(
    parameter int XLEN  = `XLEN,
    parameter int DEPTH = `WB_DEPTH
) (
    input  logic                   i_wb_clk,
    input  logic                   i_wb_rst,
    input  logic                   i_wb_ex_valid,
    input  logic [4:0]             i_wb_ex_rd,
    input  logic [XLEN-1:0]        i_wb_ex_data,
    input  logic                   i_wb_ld_valid,
    output logic                   o_wb_ld_ready,
    input  logic [4:0]             i_wb_ld_rd,
    input  logic [XLEN-1:0]        i_wb_ld_data,
    output logic                   o_rf_we,
    output logic [4:0]             o_rf_wa,
    output logic [XLEN-1:0]        o_rf_wd,
    output logic [31:0]            o_wb_busy_mask,
    output logic [$clog2(DEPTH):0] o_wb_count
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic            ex_wr_s;
    logic            ld_fire_s;
    logic            enq_s;
    logic            deq_s;
    logic            head_live_s;
    logic [4:0]      head_rd_s;
    logic [XLEN-1:0] head_data_s;
    logic [CW-1:0]   count_s;
    wb_src_e         src_s;

    logic            rf_we_q, rf_we_d;
    logic [4:0]      rf_wa_q, rf_wa_d;
    logic [XLEN-1:0] rf_wd_q, rf_wd_d;

    rv_wb_queue #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk_i       (i_wb_clk),
        .rst_i       (i_wb_rst),
        .enq_i       (enq_s),
        .enq_rd_i    (i_wb_ld_rd),
        .enq_data_i  (i_wb_ld_data),
        .deq_i       (deq_s),
        .kill_i      (ex_wr_s),
        .kill_rd_i   (i_wb_ex_rd),
        .count_o     (count_s),
        .head_live_o (head_live_s),
        .head_rd_o   (head_rd_s),
        .head_data_o (head_data_s),
        .busy_mask_o (o_wb_busy_mask)
    );

    // Handshake, x0 filter and same-cycle WAW drop decide what enters the queue.
    always_comb begin
        o_wb_ld_ready = (count_s < CW'(DEPTH));
        ex_wr_s       = i_wb_ex_valid && (i_wb_ex_rd != 5'd0);
        ld_fire_s     = i_wb_ld_valid && o_wb_ld_ready;
        if (ld_fire_s && (i_wb_ld_rd != 5'd0) && !(ex_wr_s && (i_wb_ex_rd == i_wb_ld_rd))) begin
            enq_s = 1'b1;
        end else begin
            enq_s = 1'b0;
        end
    end

    // Slot arbitration: pipeline first, otherwise pop the head (written only if live).
    always_comb begin
        src_s   = SRC_NONE;
        deq_s   = 1'b0;
        rf_we_d = 1'b0;
        rf_wa_d = 5'd0;
        rf_wd_d = {XLEN{1'b0}};
        if (ex_wr_s) begin
            src_s = SRC_EX;
        end else if (count_s != {CW{1'b0}}) begin
            src_s = SRC_LD;
        end else begin
            src_s = SRC_NONE;
        end
        case (src_s)
            SRC_EX: begin
                rf_we_d = 1'b1;
                rf_wa_d = i_wb_ex_rd;
                rf_wd_d = i_wb_ex_data;
            end
            SRC_LD: begin
                deq_s = 1'b1;
                if (head_live_s) begin
                    rf_we_d = 1'b1;
                    rf_wa_d = head_rd_s;
                    rf_wd_d = head_data_s;
                end else begin
                    rf_we_d = 1'b0;
                end
            end
            default: begin
                rf_we_d = 1'b0;
            end
        endcase
    end

    // Registered register-file write port.
    always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
        if (i_wb_rst) begin
            rf_we_q <= 1'b0;
            rf_wa_q <= 5'd0;
            rf_wd_q <= {XLEN{1'b0}};
        end else begin
            rf_we_q <= rf_we_d;
            rf_wa_q <= rf_wa_d;
            rf_wd_q <= rf_wd_d;
        end
    end

    assign o_rf_we    = rf_we_q;
    assign o_rf_wa    = rf_wa_q;
    assign o_rf_wd    = rf_wd_q;
    assign o_wb_count = count_s;

endmodule

// File: tb/tb_rv_wb_arbiter.sv
// Directed bench for rv_wb_arbiter (XLEN=32, DEPTH=4).
module tb_rv_wb_arbiter;

    logic        clk;
    logic        rst;
    logic        ex_valid;
    logic [4:0]  ex_rd;
    logic [31:0] ex_data;
    logic        ld_valid;
    logic        ld_ready;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;
    logic [31:0] busy_mask;
    logic [2:0]  count;

    int total = 0;
    int bad   = 0;

    rv_wb_arbiter #(.XLEN(32), .DEPTH(4)) dut (
        .i_wb_clk       (clk),
        .i_wb_rst       (rst),
        .i_wb_ex_valid  (ex_valid),
        .i_wb_ex_rd     (ex_rd),
        .i_wb_ex_data   (ex_data),
        .i_wb_ld_valid  (ld_valid),
        .o_wb_ld_ready  (ld_ready),
        .i_wb_ld_rd     (ld_rd),
        .i_wb_ld_data   (ld_data),
        .o_rf_we        (rf_we),
        .o_rf_wa        (rf_wa),
        .o_rf_wd        (rf_wd),
        .o_wb_busy_mask (busy_mask),
        .o_wb_count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ex_valid = 1'b0; ex_rd = 5'd0; ex_data = 32'd0;
        ld_valid = 1'b0; ld_rd = 5'd0; ld_data = 32'd0;
    endtask

    task automatic test_reset();
        total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL reset_we got=%0b exp=0", rf_we); end
        total++; if (rf_wa !== 5'd0) begin bad++; $display("FAIL reset_wa got=%0d exp=0", rf_wa); end
        total++; if (rf_wd !== 32'd0) begin bad++; $display("FAIL reset_wd got=%h exp=0", rf_wd); end
        total++; if (busy_mask !== 32'd0) begin bad++; $display("FAIL reset_mask got=%h exp=0", busy_mask); end
        total++; if (count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
        total++; if (ld_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0b exp=1", ld_ready); end
    endtask

    task automatic test_ex_write();
        ex_valid = 1'b1; ex_rd = 5'd5; ex_data = 32'hDEADBEEF;
        step();
        total++; if (rf_we !== 1'b1) begin bad++; $display("FAIL ex_we got=%0b exp=1", rf_we); end
        total++; if (rf_wa !== 5'd5) begin bad++; $display("FAIL ex_wa got=%0d exp=5", rf_wa); end
        total++; if (rf_wd !== 32'hDEADBEEF) begin bad++; $display("FAIL ex_wd got=%h exp=deadbeef", rf_wd); end
        ex_rd = 5'd0; ex_data = 32'h12345678;
        step();
        total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL ex_x0_we got=%0b exp=0", rf_we); end
        idle_inputs();
        step();
    endtask

    task automatic test_load_drain();
        ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'h00001234;
        step();
        idle_inputs();
        total++; if (busy_mask !== 32'h00000080) begin bad++; $display("FAIL ld_mask_set got=%h exp=00000080", busy_mask); end
        total++; if (count !== 3'd1) begin bad++; $display("FAIL ld_count got=%0d exp=1", count); end
        total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL ld_early_we got=%0b exp=0", rf_we); end
        step();
        total++; if (rf_we !== 1'b1) begin bad++; $display("FAIL ld_we got=%0b exp=1", rf_we); end
        total++; if (rf_wa !== 5'd7) begin bad++; $display("FAIL ld_wa got=%0d exp=7", rf_wa); end
        total++; if (rf_wd !== 32'h00001234) begin bad++; $display("FAIL ld_wd got=%h exp=00001234", rf_wd); end
        total++; if (busy_mask !== 32'd0) begin bad++; $display("FAIL ld_mask_clr got=%h exp=0", busy_mask); end
        total++; if (count !== 3'd0) begin bad++; $display("FAIL ld_count_clr got=%0d exp=0", count); end
        // x0 load is consumed but never queued
        ld_valid = 1'b1; ld_rd = 5'd0; ld_data = 32'hFFFF0000;
        step();
        idle_inputs();
        total++; if (count !== 3'd0) begin bad++; $display("FAIL ld_x0_count got=%0d exp=0", count); end
        step();
        total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL ld_x0_we got=%0b exp=0", rf_we); end
    endtask

    task automatic test_contention_full();
        for (int i = 0; i < 4; i++) begin
            ex_valid = 1'b1; ex_rd = 5'd20; ex_data = 32'hE0 + i;
            ld_valid = 1'b1; ld_rd = 5'(i + 1); ld_data = 32'hA0 + i;
            step();
            total++; if (rf_we !== 1'b1 || rf_wa !== 5'd20) begin bad++; $display("FAIL fill_ex_slot%0d got=%0b/%0d exp=1/20", i, rf_we, rf_wa); end
            total++; if (count !== 3'(i + 1)) begin bad++; $display("FAIL fill_count%0d got=%0d exp=%0d", i, count, i + 1); end
        end
        total++; if (ld_ready !== 1'b0) begin bad++; $display("FAIL full_ready got=%0b exp=0", ld_ready); end
        total++; if (busy_mask !== 32'h0000001E) begin bad++; $display("FAIL full_mask got=%h exp=0000001e", busy_mask); end
        ex_data = 32'hEE; ld_rd = 5'd31; ld_data = 32'hBAD;
        step();
        total++; if (count !== 3'd4) begin bad++; $display("FAIL full_hold_count got=%0d exp=4", count); end
        total++; if (rf_wd !== 32'hEE) begin bad++; $display("FAIL full_ex_wd got=%h exp=ee", rf_wd); end
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            step();
            total++; if (rf_we !== 1'b1 || rf_wa !== 5'(i + 1) || rf_wd !== 32'hA0 + i) begin
                bad++; $display("FAIL drain%0d got=%0b/%0d/%h exp=1/%0d/%h", i, rf_we, rf_wa, rf_wd, i + 1, 32'hA0 + i);
            end
            total++; if (count !== 3'(3 - i)) begin bad++; $display("FAIL drain_count%0d got=%0d exp=%0d", i, count, 3 - i); end
            total++; if (ld_ready !== 1'b1) begin bad++; $display("FAIL drain_ready%0d got=%0b exp=1", i, ld_ready); end
        end
        step();
        total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL drain_end_we got=%0b exp=0", rf_we); end
    endtask

    task automatic test_waw_kill();
        ld_valid = 1'b1; ld_rd = 5'd9; ld_data = 32'h55;
        step();
        idle_inputs();
        total++; if (busy_mask !== 32'h00000200) begin bad++; $display("FAIL waw_mask got=%h exp=00000200", busy_mask); end
        ex_valid = 1'b1; ex_rd = 5'd9; ex_data = 32'hAA;
        step();
        idle_inputs();
        total++; if (rf_we !== 1'b1 || rf_wa !== 5'd9 || rf_wd !== 32'hAA) begin
            bad++; $display("FAIL waw_ex got=%0b/%0d/%h exp=1/9/aa", rf_we, rf_wa, rf_wd);
        end
        total++; if (count !== 3'd1) begin bad++; $display("FAIL waw_killed_count got=%0d exp=1", count); end
        total++; if (busy_mask !== 32'd0) begin bad++; $display("FAIL waw_killed_mask got=%h exp=0", busy_mask); end
        step();
        total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL waw_pop_we got=%0b exp=0", rf_we); end
        total++; if (count !== 3'd0) begin bad++; $display("FAIL waw_pop_count got=%0d exp=0", count); end
        // same-cycle load and pipeline write to the same register
        ex_valid = 1'b1; ex_rd = 5'd9; ex_data = 32'hCC;
        ld_valid = 1'b1; ld_rd = 5'd9; ld_data = 32'h77;
        step();
        idle_inputs();
        total++; if (count !== 3'd0) begin bad++; $display("FAIL same_cycle_count got=%0d exp=0", count); end
        total++; if (rf_we !== 1'b1 || rf_wd !== 32'hCC) begin bad++; $display("FAIL same_cycle_wr got=%0b/%h exp=1/cc", rf_we, rf_wd); end
        step();
        total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL same_cycle_after got=%0b exp=0", rf_we); end
    endtask

    task automatic test_reset_mid();
        ex_valid = 1'b1; ex_rd = 5'd5; ex_data = 32'h11;
        ld_valid = 1'b1; ld_rd = 5'd3; ld_data = 32'h22;
        step();
        idle_inputs();
        total++; if (rf_we !== 1'b1 || count !== 3'd1) begin bad++; $display("FAIL pre_rst got=%0b/%0d exp=1/1", rf_we, count); end
        #2 rst = 1'b1;
        #1;
        test_reset();
        #2 rst = 1'b0;
        step();
        total++; if (rf_we !== 1'b0 || count !== 3'd0) begin bad++; $display("FAIL post_rst got=%0b/%0d exp=0/0", rf_we, count); end
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        #12;
        test_reset();
        rst = 1'b0;
        step();
        test_ex_write();
        test_load_drain();
        test_contention_full();
        test_waw_kill();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
